// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer with a power-of-two
// boxcar average and a thermometer-coded bar display.
module ultrasonic_ranger #(
    parameter int CLKS_PER_US = 40,
    parameter int PERIOD_US   = 60000,
    parameter int TRIG_US     = 20,
    parameter int MAX_US      = 3552,
    parameter int WIDTH       = 12,
    parameter int AVG_LOG2    = 3,
    parameter int NBARS       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic [WIDTH-1:0] dist_us,
    output logic             dist_valid,
    output logic             timeout,
    output logic [WIDTH-1:0] avg_us,
    output logic             avg_valid,
    output logic [NBARS-1:0] bars
);

    localparam int N    = 1 << AVG_LOG2;
    localparam int SW   = WIDTH + AVG_LOG2;
    localparam int PSW  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int PW   = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int TW   = (TRIG_US > 1) ? $clog2(TRIG_US) : 1;
    localparam int AW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int STEP = MAX_US / NBARS;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_US);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TRIG = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_MEAS = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [PSW-1:0]   presc;
    logic             tick;
    logic             echo_q1;
    logic             echo_s;
    logic [2:0]       state;
    logic [PW-1:0]    per_cnt;
    logic [TW-1:0]    trig_cnt;
    logic [WIDTH-1:0] cnt;
    logic             per_end;
    logic             emit;
    logic [WIDTH-1:0] ring [N];
    logic [AW-1:0]    wp;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    new_sum;

    assign tick    = (presc == PSW'(CLKS_PER_US - 1));
    assign per_end = tick && (per_cnt == PW'(PERIOD_US - 1));

    // A sample leaves only from the listening states; IDLE/TRIG never emit.
    assign emit = per_end &&
                  ((state == ST_WAIT) ||
                   (state == ST_MEAS) ||
                   (state == ST_DONE));

    // Microsecond prescaler, tick on the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous echo pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_q1 <= 1'b0;
            echo_s  <= 1'b0;
        end else begin
            echo_q1 <= echo;
            echo_s  <= echo_q1;
        end
    end

    // Measurement sequencer: trigger, listen for the first echo, hold to period end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            per_cnt  <= '0;
            trig_cnt <= '0;
            cnt      <= '0;
            trig     <= 1'b0;
        end else begin
            if (tick && (state != ST_IDLE) && !emit) begin
                per_cnt <= per_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (tick && enable) begin
                        state    <= ST_TRIG;
                        per_cnt  <= '0;
                        trig_cnt <= '0;
                        cnt      <= '0;
                        trig     <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (tick) begin
                        if (trig_cnt == TW'(TRIG_US - 1)) begin
                            state <= ST_WAIT;
                            trig  <= 1'b0;
                        end else begin
                            trig_cnt <= trig_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (emit) begin
                        state <= ST_IDLE;
                    end else if (tick && echo_s) begin
                        // the tick that sees the rise is the first counted one
                        state <= ST_MEAS;
                        cnt   <= WIDTH'(1);
                    end
                end
                ST_MEAS: begin
                    if (emit) begin
                        state <= ST_IDLE;
                    end else if (!echo_s) begin
                        // any later pulse in this period is ignored
                        state <= ST_DONE;
                    end else if (tick && (cnt != MAXV)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (emit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    trig  <= 1'b0;
                end
            endcase
        end
    end

    // Raw sample register, loaded on the period-end tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dist_us    <= MAXV;
            timeout    <= 1'b0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= emit;
            if (emit) begin
                if (state == ST_WAIT) begin
                    // no echo rise this period
                    dist_us <= MAXV;
                    timeout <= 1'b1;
                end else begin
                    dist_us <= cnt;
                    timeout <= (cnt == MAXV);
                end
            end
        end
    end

    assign new_sum = sum - SW'(ring[wp]) + SW'(dist_us);

    // Boxcar filter: replace the oldest entry and adjust the running sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                ring[i] <= MAXV;
            end
            sum       <= SW'(MAX_US * N);
            wp        <= '0;
            avg_us    <= MAXV;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= dist_valid;
            if (dist_valid) begin
                ring[wp] <= dist_us;
                sum      <= new_sum;
                avg_us   <= new_sum[SW-1:AVG_LOG2];
                wp       <= (wp == AW'(N - 1)) ? '0 : wp + 1'b1;
            end
        end
    end

    // Thermometer bar: segment i lights once avg_us exceeds i*STEP.
    always_comb begin
        for (int i = 0; i < NBARS; i++) begin
            bars[i] = (avg_us > WIDTH'(i * STEP));
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: drives echo pulses against the trigger timing and
// compares samples, averages and bars with a queue-based reference.
module tb_ultrasonic_ranger;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trig;
    logic [11:0] dist_us;
    logic        dist_valid;
    logic        timeout;
    logic [11:0] avg_us;
    logic        avg_valid;
    logic [7:0]  bars;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] got_d;
    logic        got_to;
    logic [11:0] got_a;
    logic [7:0]  got_b;
    int          got_nav;
    bit          got_hung;

    int mq[$];

    always #5 clk = ~clk;

    ultrasonic_ranger #(
        .CLKS_PER_US(4),
        .PERIOD_US(200),
        .TRIG_US(20),
        .MAX_US(160),
        .WIDTH(12),
        .AVG_LOG2(2),
        .NBARS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .echo(echo),
        .trig(trig),
        .dist_us(dist_us),
        .dist_valid(dist_valid),
        .timeout(timeout),
        .avg_us(avg_us),
        .avg_valid(avg_valid),
        .bars(bars)
    );

    function automatic void model_reset();
        mq = {};
        for (int i = 0; i < 4; i++) mq.push_back(160);
    endfunction

    function automatic int model_push(int s);
        int acc;
        void'(mq.pop_front());
        mq.push_back(s);
        acc = 0;
        foreach (mq[i]) acc += mq[i];
        return acc / 4;
    endfunction

    function automatic logic [7:0] exp_bars(int avg);
        int k;
        k = (avg + 19) / 20;
        if (k > 8) k = 8;
        return 8'((1 << k) - 1);
    endfunction

    function automatic int exp_sample(int len);
        if (len == 0) return 160;
        if (len / 4 > 160) return 160;
        return len / 4;
    endfunction

    function automatic logic exp_to(int len);
        return (len == 0) || (len / 4 >= 160);
    endfunction

    task run_period(input int pre, input int dly, input int len,
                    input int gap, input int len2);
        int n;
        int m;
        got_hung = 0;
        got_d = '0; got_to = 0; got_a = '0; got_b = '0; got_nav = 0;
        n = 0;
        while (trig !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (trig !== 1'b1) got_hung = 1;
        if (pre > 0) begin
            repeat (8) @(negedge clk);
            echo = 1'b1;
            repeat (pre) @(negedge clk);
            echo = 1'b0;
        end
        n = 0;
        while (trig !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (trig !== 1'b0) got_hung = 1;
        fork
            begin
                repeat (dly) @(negedge clk);
                if (len > 0) begin
                    echo = 1'b1;
                    repeat (len) @(negedge clk);
                    echo = 1'b0;
                end
                if (len2 > 0) begin
                    repeat (gap) @(negedge clk);
                    echo = 1'b1;
                    repeat (len2) @(negedge clk);
                    echo = 1'b0;
                end
            end
            begin
                m = 0;
                while (dist_valid !== 1'b1 && m < 1000) begin
                    @(negedge clk); m++;
                end
                if (dist_valid !== 1'b1) got_hung = 1;
                got_d  = dist_us;
                got_to = timeout;
                @(negedge clk);
                got_a = avg_us;
                got_b = bars;
                for (int k = 0; k < 4; k++) begin
                    if (avg_valid === 1'b1) got_nav++;
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_reset();
        int n, hi, per, nv;
        logic [11:0] d;
        logic t;
        reset = 1'b1; enable = 1'b1; echo = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (trig !== 1'b0) $display("FAIL rst_trig got %0d want 0", trig); else n_pass++;
        n_checks++; if (dist_us !== 12'd160) $display("FAIL rst_dist got %0d want 160", dist_us); else n_pass++;
        n_checks++; if (avg_us !== 12'd160) $display("FAIL rst_avg got %0d want 160", avg_us); else n_pass++;
        n_checks++; if (bars !== 8'hFF) $display("FAIL rst_bars got %h want ff", bars); else n_pass++;
        n_checks++; if ({timeout, dist_valid, avg_valid} !== 3'b000) $display("FAIL rst_flags got %b want 000", {timeout, dist_valid, avg_valid}); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({trig, dist_us, avg_us} !== {1'b0, 12'd160, 12'd160}) $display("FAIL pre_tick got trig=%0d dist=%0d avg=%0d want 0/160/160", trig, dist_us, avg_us); else n_pass++;
        n = 1;
        while (trig !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (n !== 4) $display("FAIL first_trig_latency got %0d want 4", n); else n_pass++;
        hi = 0;
        while (trig === 1'b1 && hi < 200) begin @(negedge clk); hi++; end
        n_checks++; if (hi !== 80) $display("FAIL trig_width got %0d want 80", hi); else n_pass++;
        per = hi; nv = 0; d = '0; t = 1'b0;
        while (trig !== 1'b1 && per < 2000) begin
            @(negedge clk); per++;
            if (dist_valid === 1'b1) begin nv++; d = dist_us; t = timeout; end
        end
        n_checks++; if (per !== 804) $display("FAIL trig_period got %0d want 804", per); else n_pass++;
        n_checks++; if (nv !== 1) $display("FAIL first_valid_count got %0d want 1", nv); else n_pass++;
        n_checks++; if ({t, d} !== {1'b1, 12'd160}) $display("FAIL no_echo_first got to=%0d d=%0d want 1/160", t, d); else n_pass++;
        void'(model_push(160));
    endtask

    task automatic test_single_echo();
        int ea;
        run_period(0, 8, 200, 0, 0);
        ea = model_push(exp_sample(200));
        n_checks++; if (got_hung) $display("FAIL single_hang got 1 want 0"); else n_pass++;
        n_checks++; if (got_d > 51 || got_d < 49) $display("FAIL single_dist got %0d want 50+-1", got_d); else n_pass++;
        n_checks++; if (got_to !== 1'b0) $display("FAIL single_to got %0d want 0", got_to); else n_pass++;
        n_checks++; if (got_a !== 12'(ea)) $display("FAIL single_avg got %0d want %0d", got_a, ea); else n_pass++;
        n_checks++; if (got_b !== exp_bars(ea)) $display("FAIL single_bars got %h want %h", got_b, exp_bars(ea)); else n_pass++;
        n_checks++; if (got_nav !== 1) $display("FAIL single_avg_valid got %0d want 1", got_nav); else n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b1; echo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_avg_sequence();
        int tbl [5] = '{130, 100, 70, 40, 40};
        do_reset();
        run_period(0, 8, 0, 0, 0);
        void'(model_push(160));
        n_checks++; if ({got_hung, got_to, got_d} !== {1'b0, 1'b1, 12'd160}) $display("FAIL seq_first got hang=%0d to=%0d d=%0d want 0/1/160", got_hung, got_to, got_d); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            run_period(0, 3 + i, 160, 0, 0);
            void'(model_push(40));
            n_checks++; if (got_d > 41 || got_d < 39) $display("FAIL seq_dist[%0d] got %0d want 40+-1", i, got_d); else n_pass++;
            n_checks++; if (got_a !== 12'(tbl[i])) $display("FAIL seq_avg[%0d] got %0d want %0d", i, got_a, tbl[i]); else n_pass++;
            n_checks++; if (got_nav !== 1) $display("FAIL seq_avg_valid[%0d] got %0d want 1", i, got_nav); else n_pass++;
            if (i == 3) begin
                n_checks++; if (got_b !== 8'h03) $display("FAIL seq_bars got %h want 03", got_b); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int ea;
        run_period(0, 8, 760, 0, 0);
        ea = model_push(exp_sample(760));
        n_checks++; if ({got_hung, got_to, got_d} !== {1'b0, exp_to(760), 12'(exp_sample(760))}) $display("FAIL long_echo got hang=%0d to=%0d d=%0d want 0/1/160", got_hung, got_to, got_d); else n_pass++;
        n_checks++; if (got_a !== 12'(ea)) $display("FAIL long_avg got %0d want %0d", got_a, ea); else n_pass++;
        run_period(0, 8, 0, 0, 0);
        ea = model_push(exp_sample(0));
        n_checks++; if ({got_hung, got_to, got_d} !== {1'b0, 1'b1, 12'd160}) $display("FAIL no_echo got hang=%0d to=%0d d=%0d want 0/1/160", got_hung, got_to, got_d); else n_pass++;
        n_checks++; if (got_b !== exp_bars(ea)) $display("FAIL no_echo_bars got %h want %h", got_b, exp_bars(ea)); else n_pass++;
    endtask

    task automatic test_spurious();
        int ea;
        run_period(40, 8, 120, 40, 120);
        ea = model_push(30);
        n_checks++; if (got_hung) $display("FAIL spur_hang got 1 want 0"); else n_pass++;
        n_checks++; if (got_d > 31 || got_d < 29) $display("FAIL spur_dist got %0d want 30+-1", got_d); else n_pass++;
        n_checks++; if (got_to !== 1'b0) $display("FAIL spur_to got %0d want 0", got_to); else n_pass++;
        n_checks++; if (got_a !== 12'(ea)) $display("FAIL spur_avg got %0d want %0d", got_a, ea); else n_pass++;
    endtask

    task automatic test_async_reset();
        int n, nv;
        n = 0;
        while (trig !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (trig !== 1'b0) $display("FAIL trig_async_drop got %0d want 0", trig); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n = 0;
        while (trig !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (trig !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        repeat (8) @(negedge clk);
        echo = 1'b1;
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        echo = 1'b0;
        n_checks++; if ({trig, dist_valid} !== 2'b00) $display("FAIL meas_reset got trig=%0d dv=%0d want 0/0", trig, dist_valid); else n_pass++;
        nv = 0;
        repeat (5) begin @(negedge clk); if (dist_valid === 1'b1) nv++; end
        n_checks++; if ({avg_us, dist_us, bars} !== {12'd160, 12'd160, 8'hFF}) $display("FAIL meas_reset_state got avg=%0d dist=%0d bars=%h want 160/160/ff", avg_us, dist_us, bars); else n_pass++;
        reset = 1'b0;
        model_reset();
        repeat (700) begin @(negedge clk); if (dist_valid === 1'b1) nv++; end
        n_checks++; if (nv !== 0) $display("FAIL reset_no_valid got %0d want 0", nv); else n_pass++;
        n = 0;
        while (dist_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        n_checks++; if ({dist_valid, timeout, dist_us} !== {1'b1, 1'b1, 12'd160}) $display("FAIL post_reset_sample got dv=%0d to=%0d d=%0d want 1/1/160", dist_valid, timeout, dist_us); else n_pass++;
        void'(model_push(160));
        @(negedge clk);
        n_checks++; if (avg_us !== 12'd160) $display("FAIL post_reset_avg got %0d want 160", avg_us); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int n, nt, nv, ea;
        n = 0;
        while (trig !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        enable = 1'b0;
        run_period(0, 8, 160, 0, 0);
        ea = model_push(40);
        n_checks++; if (got_hung) $display("FAIL en_hang got 1 want 0"); else n_pass++;
        n_checks++; if (got_d > 41 || got_d < 39) $display("FAIL en_dist got %0d want 40+-1", got_d); else n_pass++;
        n_checks++; if (got_a !== 12'(ea)) $display("FAIL en_avg got %0d want %0d", got_a, ea); else n_pass++;
        nt = 0; nv = 0;
        repeat (1200) begin
            @(negedge clk);
            if (trig === 1'b1) nt++;
            if (dist_valid === 1'b1) nv++;
        end
        n_checks++; if ({nt, nv} !== {32'd0, 32'd0}) $display("FAIL en_idle got trig=%0d dv=%0d want 0/0", nt, nv); else n_pass++;
        enable = 1'b1;
        n = 0;
        while (trig !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n_checks++; if (trig !== 1'b1 || n > 4) $display("FAIL en_restart got trig=%0d after %0d want 1 within 4", trig, n); else n_pass++;
    endtask

    task automatic test_random();
        int kind, len, dly, ed, ea;
        for (int i = 0; i < 12; i++) begin
            kind = int'($urandom_range(0, 3));
            dly  = int'($urandom_range(1, 20));
            if (kind == 0) len = 0;
            else if (kind == 1) len = 4 * (160 + int'($urandom_range(0, 11)));
            else len = 4 * (1 + int'($urandom_range(0, 149)));
            run_period(0, dly, len, 0, 0);
            ed = exp_sample(len);
            ea = model_push(ed);
            n_checks++; if (got_hung) $display("FAIL rnd_hang[%0d] got 1 want 0", i); else n_pass++;
            n_checks++; if (int'(got_d) > ed + 1 || int'(got_d) + 1 < ed) $display("FAIL rnd_dist[%0d] len=%0d got %0d want %0d+-1", i, len, got_d, ed); else n_pass++;
            n_checks++; if (got_to !== exp_to(len)) $display("FAIL rnd_to[%0d] len=%0d got %0d want %0d", i, len, got_to, exp_to(len)); else n_pass++;
            n_checks++; if (got_a !== 12'(ea)) $display("FAIL rnd_avg[%0d] got %0d want %0d", i, got_a, ea); else n_pass++;
            n_checks++; if (got_b !== exp_bars(ea)) $display("FAIL rnd_bars[%0d] got %h want %h", i, got_b, exp_bars(ea)); else n_pass++;
            n_checks++; if (got_nav !== 1) $display("FAIL rnd_avg_valid[%0d] got %0d want 1", i, got_nav); else n_pass++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        echo   = 1'b0;
        test_reset();
        test_single_echo();
        test_avg_sequence();
        test_timeout();
        test_spurious();
        test_async_reset();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
